// File: rtl/bit_sampler_deser_if.sv
// -----------------------------------------------------------------------------
// bit_sampler_deser_if
//
// Output word handshake of the bit sampler / deserialiser.
//
// Signals:
//   word_data   deframed word, first received bit in the MSB
//   word_valid  word_data holds a word that has not been transferred yet
//   word_ready  consumer accepts the word when high together with word_valid
//
// Modports:
//   master  the deserialiser (drives word_data / word_valid)
//   slave   the consumer     (drives word_ready)
// -----------------------------------------------------------------------------
interface bit_sampler_deser_if #(
    parameter int WORD_LEN = 8
);
    logic [WORD_LEN-1:0] word_data;
    logic                word_valid;
    logic                word_ready;

    modport master (
        output word_data,
        output word_valid,
        input  word_ready
    );

    modport slave (
        input  word_data,
        input  word_valid,
        output word_ready
    );
endinterface

// File: rtl/bit_sampler_deser.sv
// -----------------------------------------------------------------------------
// bit_sampler_deser
//
// Data-recovery stage behind the clock-recovery block, in the same base-clock
// domain. The raw serial input is synchronised and every transition re-phases
// a sampling counter, so each bit is sampled near mid-bit using the recovered
// bit period. The sampled stream is searched for SYNC_WORD; once found, the
// following bits are deframed MSB-first into WORD_LEN-bit words and handed out
// through a valid/ready register.
//
// Ports:
//   clk           base clock
//   rst_n         asynchronous active-low reset, clears every register
//   signal_in     raw asynchronous serial input
//   bit_period    base-clock cycles per bit from the clock-recovery stage
//   period_valid  bit_period is usable (tie high if there is no qualifier)
//   bit_data      last sampled bit
//   bit_strobe    one-cycle pulse, bit_data is new this cycle
//   locked        high while the framer is in LOCKED
//   overrun       one-cycle pulse, a completed word was dropped
//   run_err       one-cycle pulse, lock lost after MAX_RUN samples without edge
//   word_if       word_data / word_valid / word_ready handshake (master side)
// -----------------------------------------------------------------------------
module bit_sampler_deser #(
    parameter int                  PERIOD_W   = 32,
    parameter int                  WORD_LEN   = 8,
    parameter logic [WORD_LEN-1:0] SYNC_WORD  = 8'hD5,
    parameter int                  MIN_PERIOD = 4,
    parameter int                  MAX_RUN    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                signal_in,
    input  logic [PERIOD_W-1:0] bit_period,
    input  logic                period_valid,
    output logic                bit_data,
    output logic                bit_strobe,
    output logic                locked,
    output logic                overrun,
    output logic                run_err,
    bit_sampler_deser_if.master word_if
);

    localparam int RUN_W = $clog2(MAX_RUN + 1);
    localparam int CNT_W = $clog2(WORD_LEN);

    localparam logic [PERIOD_W-1:0] MIN_P    = PERIOD_W'(MIN_PERIOD);
    localparam logic [PERIOD_W-1:0] ONE_P    = PERIOD_W'(1);
    localparam logic [RUN_W-1:0]    RUN_MAX  = RUN_W'(MAX_RUN);
    localparam logic [RUN_W-1:0]    RUN_ONE  = RUN_W'(1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(WORD_LEN - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    // Synchroniser and edge detector
    logic                s1;
    logic                s2;
    logic                s3;
    logic                sig_edge;

    // Sampling
    logic                active;
    logic                sample;
    logic [PERIOD_W-1:0] ph;
    logic [RUN_W-1:0]    run_cnt;
    logic                run_hit;

    // Deframing
    logic [WORD_LEN-1:0] sr;
    logic [WORD_LEN-1:0] sr_next;
    logic [CNT_W-1:0]    bit_cnt;
    state_t              state;
    logic                word_done;

    // Both edge polarities re-phase the sampler.
    assign sig_edge = s2 ^ s3;

    // Periods below MIN_PERIOD leave no room for a mid-bit sample after the
    // synchroniser delay, so they are treated like an invalid estimate.
    assign active = period_valid && (bit_period >= MIN_P);

    // An edge in the compare cycle means the phase is about to be reset;
    // that cycle is not a trustworthy mid-bit point, so the edge wins.
    assign sample = active && !sig_edge && (ph == (bit_period >> 1));

    assign sr_next = {sr[WORD_LEN-2:0], s2};

    // The sample that brings the run counter to MAX_RUN.
    assign run_hit = sample && (run_cnt == (RUN_MAX - RUN_ONE));

    // -------------------------------------------------------------------------
    // Input synchroniser: s1/s2 resolve metastability, s3 is the previous s2.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make s1/s2/s3 a true shift chain;
            // blocking ones would collapse it into a single flop.
            s1 <= signal_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // -------------------------------------------------------------------------
    // Phase counter. The >= wrap keeps the counter bounded when bit_period
    // shrinks below the current phase.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (!active || sig_edge) begin
            ph <= '0;
        end else if (ph >= (bit_period - ONE_P)) begin
            ph <= '0;
        end else begin
            ph <= ph + ONE_P;
        end
    end

    // -------------------------------------------------------------------------
    // Run counter: samples since the last edge, saturating at MAX_RUN.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if (!active || sig_edge) begin
            run_cnt <= '0;
        end else if (sample && (run_cnt != RUN_MAX)) begin
            run_cnt <= run_cnt + RUN_ONE;
        end
    end

    // -------------------------------------------------------------------------
    // Bit output and shift register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_strobe <= 1'b0;
            bit_data   <= 1'b0;
        end else begin
            bit_strobe <= sample;
            if (sample) begin
                bit_data <= s2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else if (!active) begin
            sr <= '0;
        end else if (sample) begin
            sr <= sr_next;
        end
    end

    // -------------------------------------------------------------------------
    // Framing FSM. word_done is raised one cycle after the completing sample,
    // when sr already holds the full word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= HUNT;
            locked    <= 1'b0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            run_err   <= 1'b0;
        end else begin
            word_done <= 1'b0;
            run_err   <= 1'b0;

            if (!active) begin
                state   <= HUNT;
                locked  <= 1'b0;
                bit_cnt <= '0;
            end else if (sample) begin
                case (state)
                    HUNT: begin
                        // The sync word only frames the data; it is not emitted.
                        if (sr_next == SYNC_WORD) begin
                            state   <= LOCKED;
                            locked  <= 1'b1;
                            bit_cnt <= '0;
                        end
                    end

                    LOCKED: begin
                        // Loss of lock takes priority over completing a word:
                        // a word ending in MAX_RUN unchanged samples is suspect.
                        if (run_hit) begin
                            state   <= HUNT;
                            locked  <= 1'b0;
                            bit_cnt <= '0;
                            run_err <= 1'b1;
                        end else if (bit_cnt == CNT_LAST) begin
                            bit_cnt   <= '0;
                            word_done <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_ONE;
                        end
                    end

                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output register. A completed word is accepted when the register is
    // empty or being emptied this cycle; otherwise it is dropped so that
    // word_data never changes under an untransferred word.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_if.word_data  <= '0;
            word_if.word_valid <= 1'b0;
            overrun            <= 1'b0;
        end else begin
            overrun <= 1'b0;

            if (word_done) begin
                if (!word_if.word_valid || word_if.word_ready) begin
                    word_if.word_data  <= sr;
                    word_if.word_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (word_if.word_valid && word_if.word_ready) begin
                word_if.word_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bit_sampler_deser.sv
// -----------------------------------------------------------------------------
// tb_bit_sampler_deser
//
// Self-checking bench for bit_sampler_deser. Serial streams are driven as NRZ
// bits of a chosen length; a bit-level reference model derives the expected
// sampled bits, emitted words and loss-of-lock events from the framing rules.
// A negedge monitor records what the DUT produces.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bit_sampler_deser;

    localparam int          PW      = 32;
    localparam int          WL      = 8;
    localparam logic [7:0]  SYNC    = 8'hD5;
    localparam int          MAX_RUN = 16;

    logic          clk;
    logic          rst_n;
    logic          signal_in;
    logic [PW-1:0] bit_period;
    logic          period_valid;
    logic          bit_data;
    logic          bit_strobe;
    logic          locked;
    logic          overrun;
    logic          run_err;

    bit_sampler_deser_if #(.WORD_LEN(WL)) wif ();

    bit_sampler_deser #(
        .PERIOD_W   (PW),
        .WORD_LEN   (WL),
        .SYNC_WORD  (SYNC),
        .MIN_PERIOD (4),
        .MAX_RUN    (MAX_RUN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .signal_in    (signal_in),
        .bit_period   (bit_period),
        .period_valid (period_valid),
        .bit_data     (bit_data),
        .bit_strobe   (bit_strobe),
        .locked       (locked),
        .overrun      (overrun),
        .run_err      (run_err),
        .word_if      (wif)
    );

    // Roughly 300 MHz
    initial clk = 1'b0;
    always #1.667 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- monitor ----------------
    logic       got_bits[$];
    int         strobe_cyc[$];
    logic [7:0] got_words[$];
    int         word_cyc[$];
    int         n_overrun;
    int         n_runerr;
    int         vrun;
    int         max_vrun;
    int         stab_viol = 0;
    logic       prev_valid;
    logic       prev_xfer;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (rst_n) begin
            if (bit_strobe) begin
                got_bits.push_back(bit_data);
                strobe_cyc.push_back(int'(cyc));
            end
            if (wif.word_valid && wif.word_ready) begin
                got_words.push_back(wif.word_data);
                word_cyc.push_back(int'(cyc));
            end
            if (overrun) n_overrun++;
            if (run_err) n_runerr++;
            vrun = wif.word_valid ? vrun + 1 : 0;
            if (vrun > max_vrun) max_vrun = vrun;
            if (prev_valid && !prev_xfer && wif.word_valid && (wif.word_data !== prev_data))
                stab_viol++;
            prev_valid = wif.word_valid;
            prev_xfer  = wif.word_valid && wif.word_ready;
            prev_data  = wif.word_data;
        end else begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            prev_data  = '0;
        end
    end

    // ---------------- reference model (bit level) ----------------
    logic [7:0] m_sr;
    logic       m_locked;
    int         m_cnt;
    int         m_run;
    logic       m_prev;
    logic [7:0] exp_words[$];
    int         exp_runerr;
    logic       sent_bits[$];
    int         dper;
    int         half;
    int         last_start;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #0.1;
    endtask

    task automatic clear_monitor();
        got_bits.delete();
        strobe_cyc.delete();
        got_words.delete();
        word_cyc.delete();
        n_overrun = 0;
        n_runerr  = 0;
        vrun      = 0;
        max_vrun  = 0;
    endtask

    // Run length counts samples since the last level change; the sample that
    // makes it MAX_RUN while locked drops lock instead of counting a bit.
    task automatic model_step(input logic b);
        int   newrun;
        logic hit;
        newrun = (b === m_prev) ? ((m_run < MAX_RUN) ? m_run + 1 : MAX_RUN) : 1;
        hit    = (m_run == MAX_RUN - 1) && (newrun == MAX_RUN);
        m_sr   = {m_sr[6:0], b};
        if (!m_locked) begin
            if (m_sr == SYNC) begin
                m_locked = 1'b1;
                m_cnt    = 0;
            end
        end else if (hit) begin
            exp_runerr++;
            m_locked = 1'b0;
            m_cnt    = 0;
        end else if (m_cnt == WL - 1) begin
            exp_words.push_back(m_sr);
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
        m_run  = newrun;
        m_prev = b;
    endtask

    // Called at drive time (just after a rising edge).
    task automatic start_session(input int per, input int drive_per);
        bit_period = PW'(per);
        dper       = drive_per;
        half       = per / 2;
        m_sr       = '0;
        m_locked   = 1'b0;
        m_cnt      = 0;
        m_run      = 0;
        m_prev     = signal_in;
        exp_words.delete();
        exp_runerr = 0;
        sent_bits.delete();
        clear_monitor();
        period_valid = 1'b1;
    endtask

    task automatic send_bit(input logic b);
        signal_in = b;
        model_step(b);
        sent_bits.push_back(b);
        last_start = int'(cyc);
        tick(dper);
    endtask

    task automatic send_byte(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    // Keeps the estimate valid just long enough for the last bit's sample,
    // then drops it so no further samples occur, and drains the pipeline.
    task automatic end_session(input string name);
        if (half + 4 > dper) tick(half + 4 - dper);
        n_checks++;
        if (locked !== m_locked) begin
            n_errors++;
            $display("FAIL %s locked: got %b expected %b", name, locked, m_locked);
        end
        period_valid = 1'b0;
        tick(6);
    endtask

    task automatic check_stream(input string name);
        int bad;
        bad = -1;
        if (got_bits.size() == sent_bits.size())
            foreach (sent_bits[i]) if (got_bits[i] !== sent_bits[i] && bad < 0) bad = i;
        n_checks++;
        if (got_bits.size() != sent_bits.size() || bad >= 0) begin
            n_errors++;
            $display("FAIL %s bits: got %0d bits expected %0d, first diff at %0d",
                     name, got_bits.size(), sent_bits.size(), bad);
        end
        bad = -1;
        if (got_words.size() == exp_words.size())
            foreach (exp_words[i]) if (got_words[i] !== exp_words[i] && bad < 0) bad = i;
        n_checks++;
        if (got_words.size() != exp_words.size() || bad >= 0) begin
            n_errors++;
            $display("FAIL %s words: got %0d words (first %h) expected %0d (first %h), diff at %0d",
                     name, got_words.size(), (got_words.size() > 0) ? got_words[0] : 8'h00,
                     exp_words.size(), (exp_words.size() > 0) ? exp_words[0] : 8'h00, bad);
        end
        n_checks++;
        if (n_runerr != exp_runerr) begin
            n_errors++;
            $display("FAIL %s run_err: got %0d expected %0d", name, n_runerr, exp_runerr);
        end
        n_checks++;
        if (n_overrun != 0) begin
            n_errors++;
            $display("FAIL %s overrun: got %0d expected 0", name, n_overrun);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        tick(4);
        n_checks++;
        if ({bit_data, bit_strobe, locked, overrun, run_err, wif.word_valid, wif.word_data} !== '0) begin
            n_errors++;
            $display("FAIL reset outputs: got %b expected all 0",
                     {bit_data, bit_strobe, locked, overrun, run_err, wif.word_valid, wif.word_data});
        end
        rst_n = 1'b1;
        tick(4);
        n_checks++;
        if ({bit_strobe, locked, wif.word_valid} !== 3'b000) begin
            n_errors++;
            $display("FAIL idle after reset: got %b expected 000", {bit_strobe, locked, wif.word_valid});
        end
    endtask

    task automatic test_basic();
        int a3_last;
        logic [7:0] d5;
        d5 = SYNC;
        wif.word_ready = 1'b1;
        start_session(10, 10);
        for (int i = 7; i >= 1; i--) send_bit(d5[i]);
        n_checks++;
        if (locked !== 1'b0) begin
            n_errors++;
            $display("FAIL basic early lock: got %b expected 0", locked);
        end
        send_bit(d5[0]);
        n_checks++;
        if (locked !== 1'b1) begin
            n_errors++;
            $display("FAIL basic lock after sync: got %b expected 1", locked);
        end
        send_byte(8'hA3);
        a3_last = last_start;
        send_byte(8'h5C);
        end_session("basic");
        check_stream("basic");
        n_checks++;
        if (got_words.size() != 2 || got_words[0] !== 8'hA3 || got_words[1] !== 8'h5C) begin
            n_errors++;
            $display("FAIL basic word values: got %0d words expected A3,5C", got_words.size());
        end
        n_checks++;
        if (word_cyc.size() < 1 || word_cyc[0] != a3_last + 10) begin
            n_errors++;
            $display("FAIL basic word latency: got cycle %0d expected %0d",
                     (word_cyc.size() > 0) ? word_cyc[0] : -1, a3_last + 10);
        end
        n_checks++;
        if (max_vrun != 1) begin
            n_errors++;
            $display("FAIL basic valid width: got %0d expected 1", max_vrun);
        end
    endtask

    task automatic test_backpressure();
        wif.word_ready = 1'b0;
        start_session(10, 10);
        send_byte(SYNC);
        send_byte(8'hA3);
        send_byte(8'h5C);
        end_session("backpressure");
        n_checks++;
        if (wif.word_valid !== 1'b1 || wif.word_data !== 8'hA3) begin
            n_errors++;
            $display("FAIL backpressure hold: got valid=%b data=%h expected valid=1 data=a3",
                     wif.word_valid, wif.word_data);
        end
        n_checks++;
        if (n_overrun != 1) begin
            n_errors++;
            $display("FAIL backpressure overrun: got %0d expected 1", n_overrun);
        end
        n_checks++;
        if (got_words.size() != 0) begin
            n_errors++;
            $display("FAIL backpressure early transfer: got %0d expected 0", got_words.size());
        end
        wif.word_ready = 1'b1;
        tick(1);
        wif.word_ready = 1'b0;
        tick(2);
        n_checks++;
        if (wif.word_valid !== 1'b0 || got_words.size() != 1 || got_words[0] !== 8'hA3) begin
            n_errors++;
            $display("FAIL backpressure drain: got valid=%b words=%0d expected valid=0 words=1 (a3)",
                     wif.word_valid, got_words.size());
        end
        wif.word_ready = 1'b1;
    endtask

    task automatic test_run_err();
        wif.word_ready = 1'b1;
        start_session(10, 10);
        send_byte(SYNC);
        repeat (20) send_bit(1'b1);
        n_checks++;
        if (locked !== 1'b0 || n_runerr != 1) begin
            n_errors++;
            $display("FAIL run_err lock loss: got locked=%b run_err=%0d expected locked=0 run_err=1",
                     locked, n_runerr);
        end
        send_byte(SYNC);
        send_byte(8'($urandom));
        end_session("run_err");
        check_stream("run_err");
    endtask

    task automatic test_period_sweep();
        int starts[$];
        int bad;
        clear_monitor();
        bit_period   = PW'(3);
        period_valid = 1'b1;
        for (int i = 0; i < 24; i++) begin
            signal_in = ~signal_in;
            tick(3);
        end
        tick(20);
        n_checks++;
        if (got_bits.size() != 0) begin
            n_errors++;
            $display("FAIL period3 strobes: got %0d expected 0", got_bits.size());
        end
        period_valid = 1'b0;
        tick(5);

        start_session(4, 4);
        for (int i = 0; i < 12; i++) begin
            send_bit(~signal_in);
            starts.push_back(last_start);
        end
        end_session("period4");
        check_stream("period4");
        bad = -1;
        if (strobe_cyc.size() == 12)
            foreach (starts[i]) if (strobe_cyc[i] != starts[i] + 6 && bad < 0) bad = i;
        n_checks++;
        if (strobe_cyc.size() != 12 || bad >= 0) begin
            n_errors++;
            $display("FAIL period4 strobe timing: got %0d strobes, first bad index %0d, expected 12 at start+6",
                     strobe_cyc.size(), bad);
        end
    endtask

    task automatic test_drift();
        wif.word_ready = 1'b1;
        start_session(10, 11);
        send_byte(SYNC);
        send_byte(8'h3C);
        end_session("drift");
        check_stream("drift");
        n_checks++;
        if (got_words.size() != 1 || got_words[0] !== 8'h3C) begin
            n_errors++;
            $display("FAIL drift word: got %0d words (first %h) expected 1 word 3c",
                     got_words.size(), (got_words.size() > 0) ? got_words[0] : 8'h00);
        end
    endtask

    task automatic test_random();
        int per;
        int pre;
        wif.word_ready = 1'b1;
        for (int it = 0; it < 4; it++) begin
            per = int'($urandom_range(4, 16));
            pre = int'($urandom_range(0, 6));
            start_session(per, per);
            for (int i = 0; i < pre; i++) send_bit(1'($urandom));
            send_byte(SYNC);
            for (int w = 0; w < 3; w++) send_byte(8'($urandom));
            end_session("random");
            check_stream("random");
        end
    endtask

    task automatic test_async_reset();
        wif.word_ready = 1'b0;
        start_session(10, 10);
        send_byte(SYNC);
        send_byte(8'hA3);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        n_checks++;
        if (locked !== 1'b1 || wif.word_valid !== 1'b1 || wif.word_data !== 8'hA3) begin
            n_errors++;
            $display("FAIL pre-reset state: got locked=%b valid=%b data=%h expected 1 1 a3",
                     locked, wif.word_valid, wif.word_data);
        end
        #0.5 rst_n = 1'b0;
        #0.2;
        n_checks++;
        if ({bit_data, bit_strobe, locked, overrun, run_err, wif.word_valid, wif.word_data} !== '0) begin
            n_errors++;
            $display("FAIL async reset outputs: got %b expected all 0",
                     {bit_data, bit_strobe, locked, overrun, run_err, wif.word_valid, wif.word_data});
        end
        signal_in = 1'b0;
        tick(3);
        rst_n = 1'b1;
        wif.word_ready = 1'b1;
        start_session(10, 10);
        send_byte(8'h3C);
        n_checks++;
        if (locked !== 1'b0 || got_words.size() != 0) begin
            n_errors++;
            $display("FAIL post-reset hunt: got locked=%b words=%0d expected 0 0", locked, got_words.size());
        end
        send_byte(SYNC);
        send_byte(8'h96);
        end_session("post_reset");
        check_stream("post_reset");
        n_checks++;
        if (got_words.size() != 1 || got_words[0] !== 8'h96) begin
            n_errors++;
            $display("FAIL post-reset word: got %0d words expected 1 word 96", got_words.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        signal_in      = 1'b0;
        bit_period     = PW'(10);
        period_valid   = 1'b0;
        wif.word_ready = 1'b0;

        test_reset();
        test_basic();
        test_backpressure();
        test_run_err();
        test_period_sweep();
        test_drift();
        test_random();
        test_async_reset();

        n_checks++;
        if (stab_viol != 0) begin
            n_errors++;
            $display("FAIL word_data stability: got %0d changes while held, expected 0", stab_viol);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
